// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, bit-rate strobe,
// selectable bit order, programmable inter-word idle gap and word-done pulse.
module piso_serializer #(
    parameter int unsigned WIDTH      = 10,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b1,
    parameter int unsigned GAP        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W = 8;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP);
    localparam bit HAS_GAP = (GAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    // Bit that leaves the word next, and the word with that bit removed.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign load_ready = shift_en &
                        ((state_q == ST_IDLE) |
                         ((state_q == ST_SHIFT) & (bit_cnt_q == LAST_BIT) & !HAS_GAP) |
                         ((state_q == ST_GAP) & (gap_cnt_q == GAP_LAST)));
    assign accept = load_valid & load_ready;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sreg_d     = sreg_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;

        if (shift_en) begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SHIFT: begin
                    if (bit_cnt_q < LAST_BIT) begin
                        data_out_d = first_bit(sreg_q);
                        sreg_d     = shift_word(sreg_q);
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end else begin
                        done_d     = 1'b1;
                        data_out_d = IDLE_LEVEL;
                        if (HAS_GAP) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_W'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != GAP_LAST) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // An accepted word overrides the end-of-word/gap fallthrough: first bit goes out now.
        if (accept) begin
            sreg_d     = shift_word(data_in);
            data_out_d = first_bit(data_in);
            bit_cnt_d  = CNT_W'(1);
            state_d    = ST_SHIFT;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sreg_q     <= '0;
            data_out_q <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sreg_q     <= sreg_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share one stimulus stream and
// are each compared against a queue-of-line-levels reference model.
module tb_piso_serializer;

    localparam int W = 10;
    localparam int N = 3;

    logic         clk;
    logic         reset;
    logic         shift_en;
    logic         load_valid;
    logic [W-1:0] data_in;
    logic [N-1:0] rdy, dout, busy, done;

    int checks;
    int failures;

    // Per-instance configuration: bit order, gap length, idle level.
    bit msb_cfg [N] = '{1'b0, 1'b1, 1'b0};
    int gap_cfg [N] = '{0, 0, 2};
    bit idl_cfg [N] = '{1'b1, 1'b0, 1'b1};

    // Model: line levels still to be driven on future strobes after the current one.
    bit          m_act   [N];
    logic [31:0] m_line  [N];
    int          m_len   [N];
    int          m_since [N];
    logic        m_out   [N];
    logic        m_done  [N];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP(0)) u_lsb (
        .clk(clk), .reset(reset), .shift_en(shift_en), .data_in(data_in),
        .load_valid(load_valid), .load_ready(rdy[0]), .data_out(dout[0]),
        .busy(busy[0]), .done(done[0]));

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP(0)) u_msb (
        .clk(clk), .reset(reset), .shift_en(shift_en), .data_in(data_in),
        .load_valid(load_valid), .load_ready(rdy[1]), .data_out(dout[1]),
        .busy(busy[1]), .done(done[1]));

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP(2)) u_gap (
        .clk(clk), .reset(reset), .shift_en(shift_en), .data_in(data_in),
        .load_valid(load_valid), .load_ready(rdy[2]), .data_out(dout[2]),
        .busy(busy[2]), .done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0b expected=%0b t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) begin
            m_act[k]   = 1'b0;
            m_line[k]  = '0;
            m_len[k]   = 0;
            m_since[k] = 0;
            m_out[k]   = idl_cfg[k];
            m_done[k]  = 1'b0;
        end
    endtask

    function automatic logic m_ready(input int k, input logic se);
        return se && (!m_act[k] || m_len[k] == 0);
    endfunction

    // Word becomes a list of line levels: W data bits in send order then gap idles.
    task automatic m_accept(input int k, input logic [W-1:0] w);
        logic [31:0] seq;
        seq = '0;
        for (int i = 0; i < W; i++) seq[i] = msb_cfg[k] ? w[W-1-i] : w[i];
        for (int g = 0; g < gap_cfg[k]; g++) seq[W+g] = idl_cfg[k];
        m_out[k]   = seq[0];
        m_line[k]  = seq >> 1;
        m_len[k]   = W - 1 + gap_cfg[k];
        m_since[k] = 0;
        m_act[k]   = 1'b1;
    endtask

    task automatic m_edge(input int k, input logic se, input logic lv, input logic [W-1:0] d);
        m_done[k] = 1'b0;
        if (se) begin
            if (!m_act[k]) begin
                if (lv) m_accept(k, d);
            end else begin
                m_since[k]++;
                if (m_since[k] == W) m_done[k] = 1'b1;
                if (m_len[k] > 0) begin
                    m_out[k]  = m_line[k][0];
                    m_line[k] = m_line[k] >> 1;
                    m_len[k]--;
                end else if (lv) begin
                    m_accept(k, d);
                end else begin
                    m_act[k] = 1'b0;
                    m_out[k] = idl_cfg[k];
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < N; k++) begin
            check({tag, ".data_out"}, k, dout[k], m_out[k]);
            check({tag, ".busy"}, k, busy[k], m_act[k]);
            check({tag, ".done"}, k, done[k], m_done[k]);
        end
    endtask

    // One clock: drive inputs, check ready mid-cycle, advance model, check outputs after edge.
    task automatic step(input string tag, input logic se, input logic lv, input logic [W-1:0] d);
        shift_en   = se;
        load_valid = lv;
        data_in    = d;
        @(negedge clk);
        for (int k = 0; k < N; k++) check({tag, ".load_ready"}, k, rdy[k], m_ready(k, se));
        @(posedge clk);
        for (int k = 0; k < N; k++) m_edge(k, se, lv, d);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        shift_en   = 1'b0;
        load_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_reset();
        check_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs({tag, ".post"});
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        shift_en   = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        m_reset();
        #3;
        check_outputs("reset");
        @(negedge clk);
        for (int k = 0; k < N; k++) check("reset.load_ready", k, rdy[k], 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word, full-rate strobe; data_in scrambled after the accept edge.
        step("single", 1'b1, 1'b1, 10'h2B5);
        for (int i = 0; i < 14; i++) step("single", 1'b1, 1'b0, W'($urandom));

        // Back-to-back words with load_valid held.
        step("b2b", 1'b1, 1'b1, 10'h3FF);
        for (int i = 0; i < 24; i++) step("b2b", 1'b1, 1'b1, 10'h000);
        for (int i = 0; i < 14; i++) step("b2b", 1'b1, 1'b0, 10'h000);

        // Strobe every 4th clock, two words queued.
        for (int i = 0; i < 120; i++)
            step("slow", (i % 4) == 0, i < 60, (i < 4) ? 10'h155 : 10'h0F3);
        for (int i = 0; i < 20; i++) step("slow", (i % 4) == 0, 1'b0, 10'h000);

        // Abort mid-word, then restart from bit 0.
        step("abort", 1'b1, 1'b1, 10'h1C6);
        for (int i = 0; i < 4; i++) step("abort", 1'b1, 1'b0, W'($urandom));
        do_reset("abort.rst");
        for (int i = 0; i < 14; i++) step("restart", 1'b1, i == 0, 10'h2D9);

        // load_valid pulsed while the current word is in flight.
        step("ignore", 1'b1, 1'b1, 10'h0AA);
        for (int i = 0; i < 6; i++) step("ignore", 1'b1, i[0], W'($urandom));
        for (int i = 0; i < 12; i++) step("ignore", 1'b1, 1'b0, W'($urandom));

        // Random traffic at full and sparse strobe rates.
        for (int i = 0; i < 500; i++)
            step("rand_full", 1'b1, ($urandom % 3) != 0, W'($urandom));
        for (int i = 0; i < 800; i++)
            step("rand_sparse", ($urandom % 3) == 0, ($urandom % 2) == 0, W'($urandom));
        do_reset("final.rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
